controller_multi_cycle: RTL and testbench

Main sequencing FSM for the multi-cycle RV32I core. Instruction and data share one memory port; one ALU is reused for PC+4, branch/jump targets and execution. The block steps each instruction through fetch, decode, execute, memory and writeback states, waits on memory readiness, and drives every datapath mux and write enable. It decodes the same opcode set as the single-cycle main controller: 51, 3, 19, 35, 111, 99, 55 and 103.

---
 rtl/rv_ctrl_pkg.sv | 97 +++++++++
 rtl/controller_multi_cycle_if.sv | 45 ++++
 rtl/branch_cond.sv | 32 +++
 rtl/controller_multi_cycle.sv | 190 +++++++++++++++++++
 tb/tb_controller_multi_cycle.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rv_ctrl_pkg
// Shared constants for the RV32I control path: opcode values, multi-cycle
// FSM state codes, datapath mux / ALU / immediate encodings and the branch
// funct3 values. Also provides small decode helpers used by the controllers.
// No ports (package).
// ---------------------------------------------------------------------------
package rv_ctrl_pkg;

  // Opcodes handled by the core
  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_R      = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  // Multi-cycle FSM state codes (also visible on state_dbg)
  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_ALU_WB    = 4'd8;
  localparam logic [3:0] S_BRANCH    = 4'd9;
  localparam logic [3:0] S_JAL       = 4'd10;
  localparam logic [3:0] S_JALR      = 4'd11;
  localparam logic [3:0] S_LINK      = 4'd12;
  localparam logic [3:0] S_LUI       = 4'd13;

  // Result bus source
  localparam logic [1:0] RES_ALU_OUT    = 2'b00;
  localparam logic [1:0] RES_MDR        = 2'b01;
  localparam logic [1:0] RES_ALU_RESULT = 2'b10;
  localparam logic [1:0] RES_IMM        = 2'b11;

  // ALU operand A source
  localparam logic [1:0] SRC_A_PC     = 2'b00;
  localparam logic [1:0] SRC_A_OLD_PC = 2'b01;
  localparam logic [1:0] SRC_A_RS1    = 2'b10;

  // ALU operand B source
  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  // ALU operation class
  localparam logic [1:0] ALU_ADD    = 2'b00;
  localparam logic [1:0] ALU_SUB    = 2'b01;
  localparam logic [1:0] ALU_RFUNCT = 2'b10;
  localparam logic [1:0] ALU_IFUNCT = 2'b11;

  // Immediate format
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // Branch funct3 values
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;

  // Immediate format selected purely from the opcode; unknown opcodes fall
  // back to the I format so the extender always sees a defined select.
  function automatic logic [2:0] imm_src_for(input logic [6:0] opcode);
    logic [2:0] sel;
    sel = IMM_I;
    case (opcode)
      OP_STORE:  sel = IMM_S;
      OP_BRANCH: sel = IMM_B;
      OP_JAL:    sel = IMM_J;
      OP_LUI:    sel = IMM_U;
      default:   sel = IMM_I;
    endcase
    return sel;
  endfunction

  function automatic logic is_known_opcode(input logic [6:0] opcode);
    logic known;
    known = 1'b0;
    case (opcode)
      OP_LOAD, OP_IMM, OP_STORE, OP_R,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: known = 1'b1;
      default:                            known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/controller_multi_cycle_if.sv
// ---------------------------------------------------------------------------
// controller_multi_cycle_if
// Bundle between the multi-cycle controller and the datapath.
//   Datapath -> controller: opcode, funct3, zero, neg, mem_ready
//   Controller -> datapath: pc_write, adr_src, mem_write, ir_write,
//     result_src, alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
//     illegal_instr, state_dbg
// master = controller side, slave = datapath side.
// ---------------------------------------------------------------------------
interface controller_multi_cycle_if;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       zero;
  logic       neg;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [2:0] imm_src;
  logic       reg_write;
  logic       illegal_instr;
  logic [3:0] state_dbg;

  modport master (
    input  opcode, funct3, zero, neg, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
           illegal_instr, state_dbg
  );

  modport slave (
    output opcode, funct3, zero, neg, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, result_src,
           alu_src_a, alu_src_b, alu_op, imm_src, reg_write,
           illegal_instr, state_dbg
  );

endinterface

// File: rtl/branch_cond.sv
// ---------------------------------------------------------------------------
// branch_cond
// Combinational branch decision from the ALU compare flags.
//   funct3 in  3  branch type (BEQ/BNE/BLT/BGE)
//   zero   in  1  ALU result == 0
//   neg    in  1  ALU signed result < 0
//   taken  out 1  branch is taken
// Unsupported funct3 values are treated as not taken.
// ---------------------------------------------------------------------------
module branch_cond
  import rv_ctrl_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       neg,
  output logic       taken
);

  // The ALU computes rs1 - rs2, so equality is the zero flag and signed
  // less-than is the neg flag.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = zero;
      F3_BNE:  taken = ~zero;
      F3_BLT:  taken = neg;
      F3_BGE:  taken = ~neg;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/controller_multi_cycle.sv
// ---------------------------------------------------------------------------
// controller_multi_cycle
// Main sequencing FSM of the multi-cycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback on a shared memory port and
// a single reused ALU, and drives all datapath selects and write enables.
//   clk   in  1  system clock
//   rst_n in  1  asynchronous active-low reset (forces FETCH)
//   ctrl  master modport of controller_multi_cycle_if (see that file)
// Outputs are Moore on the state register, except that FETCH loads and the
// BRANCH PC load are gated by mem_ready and the branch flags respectively.
// ---------------------------------------------------------------------------
module controller_multi_cycle
  import rv_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  controller_multi_cycle_if.master ctrl
);

  logic [3:0] state_q;
  logic [3:0] state_d;
  logic       branch_taken;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic       reg_write;
  logic       illegal_instr;

  branch_cond u_branch_cond (
    .funct3 (ctrl.funct3),
    .zero   (ctrl.zero),
    .neg    (ctrl.neg),
    .taken  (branch_taken)
  );

  // State register; reset drops the FSM back to FETCH even mid-instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Unknown opcodes in DECODE and unreachable state codes
  // both fall back to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:     state_d = ctrl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctrl.opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM_ADR;
          OP_R:              state_d = S_EXEC_R;
          OP_IMM:            state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FETCH;
        endcase
      end
      S_MEM_ADR:   state_d = (ctrl.opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  state_d = ctrl.mem_ready ? S_MEM_WB : S_MEM_READ;
      S_MEM_WB:    state_d = S_FETCH;
      S_MEM_WRITE: state_d = ctrl.mem_ready ? S_FETCH : S_MEM_WRITE;
      S_EXEC_R:    state_d = S_ALU_WB;
      S_EXEC_I:    state_d = S_ALU_WB;
      S_ALU_WB:    state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_JAL:       state_d = S_ALU_WB;
      S_JALR:      state_d = S_LINK;
      S_LINK:      state_d = S_ALU_WB;
      S_LUI:       state_d = S_FETCH;
      default:     state_d = S_FETCH;
    endcase
  end

  // Output decode. DECODE precomputes old_pc + imm so a branch or JAL target
  // is already in alu_out; JAL then reuses the ALU for old_pc + 4 as the
  // link value, and JALR does the same in LINK after loading the PC. Strobes
  // are forced low while reset is asserted because FETCH would otherwise
  // follow mem_ready.
  always_comb begin
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    result_src    = RES_ALU_OUT;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    reg_write     = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = SRC_B_FOUR;
        result_src = RES_ALU_RESULT;
        ir_write   = ctrl.mem_ready;
        pc_write   = ctrl.mem_ready;
      end
      S_DECODE: begin
        alu_src_a     = SRC_A_OLD_PC;
        alu_src_b     = SRC_B_IMM;
        illegal_instr = ~is_known_opcode(ctrl.opcode);
      end
      S_MEM_ADR: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
      end
      S_MEM_WB: begin
        result_src = RES_MDR;
        reg_write  = 1'b1;
      end
      S_MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_RFUNCT;
      end
      S_EXEC_I: begin
        alu_src_a = SRC_A_RS1;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_IFUNCT;
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_RS1;
        alu_op    = ALU_SUB;
        pc_write  = branch_taken;
      end
      S_JAL: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
        pc_write  = 1'b1;
      end
      S_JALR: begin
        alu_src_a  = SRC_A_RS1;
        alu_src_b  = SRC_B_IMM;
        result_src = RES_ALU_RESULT;
        pc_write   = 1'b1;
      end
      S_LINK: begin
        alu_src_a = SRC_A_OLD_PC;
        alu_src_b = SRC_B_FOUR;
      end
      S_LUI: begin
        result_src = RES_IMM;
        reg_write  = 1'b1;
      end
      default: begin
        pc_write = 1'b0;
      end
    endcase
    if (!rst_n) begin
      pc_write      = 1'b0;
      ir_write      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  assign ctrl.pc_write      = pc_write;
  assign ctrl.adr_src       = adr_src;
  assign ctrl.mem_write     = mem_write;
  assign ctrl.ir_write      = ir_write;
  assign ctrl.result_src    = result_src;
  assign ctrl.alu_src_a     = alu_src_a;
  assign ctrl.alu_src_b     = alu_src_b;
  assign ctrl.alu_op        = alu_op;
  assign ctrl.imm_src       = imm_src_for(ctrl.opcode);
  assign ctrl.reg_write     = reg_write;
  assign ctrl.illegal_instr = illegal_instr;
  assign ctrl.state_dbg     = state_q;

endmodule

// File: tb/tb_controller_multi_cycle.sv
// ---------------------------------------------------------------------------
// tb_controller_multi_cycle
// Self-checking bench for controller_multi_cycle. Each instruction is
// expanded into its expected sequence of state codes; wait states repeat
// while mem_ready is low, and every cycle the state and the full control
// word are compared against a per-state table of expected outputs.
// ---------------------------------------------------------------------------
module tb_controller_multi_cycle;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_a;
    logic [1:0] alu_b;
    logic [1:0] alu_op;
    logic [2:0] imm_src;
    logic       reg_write;
    logic       illegal;
  } ctrl_vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  controller_multi_cycle_if ctrl_bus ();

  controller_multi_cycle dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ctrl  (ctrl_bus)
  );

  ctrl_vec_t dut_vec;
  assign dut_vec = '{ctrl_bus.pc_write, ctrl_bus.adr_src, ctrl_bus.mem_write,
                     ctrl_bus.ir_write, ctrl_bus.result_src, ctrl_bus.alu_src_a,
                     ctrl_bus.alu_src_b, ctrl_bus.alu_op, ctrl_bus.imm_src,
                     ctrl_bus.reg_write, ctrl_bus.illegal_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'd35:   return 3'b001;
      7'd99:   return 3'b010;
      7'd111:  return 3'b011;
      7'd55:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic known_op(input logic [6:0] op);
    return (op == 7'd51) || (op == 7'd3) || (op == 7'd19) || (op == 7'd35) ||
           (op == 7'd111) || (op == 7'd99) || (op == 7'd55) || (op == 7'd103);
  endfunction

  function automatic logic taken_of(input logic [2:0] f3, input logic z, input logic n);
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n;
      3'b101:  return !n;
      default: return 1'b0;
    endcase
  endfunction

  // Expected control word for a given state code.
  function automatic ctrl_vec_t model_out(input int st, input logic [6:0] op,
                                          input logic [2:0] f3, input logic z,
                                          input logic n, input logic rdy);
    ctrl_vec_t v;
    v = '0;
    v.imm_src = imm_of(op);
    case (st)
      0:  begin v.alu_b = 2'b10; v.result_src = 2'b10; v.ir_write = rdy; v.pc_write = rdy; end
      1:  begin v.alu_a = 2'b01; v.alu_b = 2'b01; v.illegal = !known_op(op); end
      2:  begin v.alu_a = 2'b10; v.alu_b = 2'b01; end
      3:  begin v.adr_src = 1'b1; end
      4:  begin v.result_src = 2'b01; v.reg_write = 1'b1; end
      5:  begin v.adr_src = 1'b1; v.mem_write = 1'b1; end
      6:  begin v.alu_a = 2'b10; v.alu_op = 2'b10; end
      7:  begin v.alu_a = 2'b10; v.alu_b = 2'b01; v.alu_op = 2'b11; end
      8:  begin v.reg_write = 1'b1; end
      9:  begin v.alu_a = 2'b10; v.alu_op = 2'b01; v.pc_write = taken_of(f3, z, n); end
      10: begin v.alu_a = 2'b01; v.alu_b = 2'b10; v.pc_write = 1'b1; end
      11: begin v.alu_a = 2'b10; v.alu_b = 2'b01; v.result_src = 2'b10; v.pc_write = 1'b1; end
      12: begin v.alu_a = 2'b01; v.alu_b = 2'b10; end
      13: begin v.result_src = 2'b11; v.reg_write = 1'b1; end
      default: v = '0;
    endcase
    return v;
  endfunction

  // Runs one instruction from FETCH to its last state. Bit k of ready_mask is
  // mem_ready on the k-th cycle of the instruction (1 beyond bit 31).
  task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3,
                               input logic z, input logic n,
                               input logic [31:0] ready_mask);
    int path[$];
    int idx;
    int k;
    int st;
    logic rdy;
    ctrl_vec_t exp_v;
    path = '{0, 1};
    case (op)
      7'd3:    begin path.push_back(2); path.push_back(3); path.push_back(4); end
      7'd35:   begin path.push_back(2); path.push_back(5); end
      7'd51:   begin path.push_back(6); path.push_back(8); end
      7'd19:   begin path.push_back(7); path.push_back(8); end
      7'd99:   path.push_back(9);
      7'd111:  begin path.push_back(10); path.push_back(8); end
      7'd103:  begin path.push_back(11); path.push_back(12); path.push_back(8); end
      7'd55:   path.push_back(13);
      default: path = '{0, 1};
    endcase
    ctrl_bus.opcode = op;
    ctrl_bus.funct3 = f3;
    ctrl_bus.zero   = z;
    ctrl_bus.neg    = n;
    idx = 0;
    k   = 0;
    while (idx < path.size() && k < 64) begin
      rdy = (k < 32) ? ready_mask[k] : 1'b1;
      ctrl_bus.mem_ready = rdy;
      #1;
      st = path[idx];
      exp_v = model_out(st, op, f3, z, n, rdy);
      checkOutput("state", 32'(ctrl_bus.state_dbg), 32'(st));
      checkOutput("ctrl_word", 32'(dut_vec), 32'(exp_v));
      if (!((st == 0 || st == 3 || st == 5) && !rdy)) idx++;
      k++;
      @(posedge clk);
      #1;
    end
    if (idx < path.size()) checkOutput("timeout", 32'(idx), 32'(path.size()));
  endtask

  logic [6:0] op_table [11] = '{7'd51, 7'd3, 7'd19, 7'd35, 7'd111, 7'd99,
                                7'd55, 7'd103, 7'h7F, 7'h0F, 7'h73};

  initial begin
    ctrl_vec_t exp_v;
    logic [31:0] mask;
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    ctrl_bus.opcode    = 7'd0;
    ctrl_bus.funct3    = 3'd0;
    ctrl_bus.zero      = 1'b0;
    ctrl_bus.neg       = 1'b0;
    ctrl_bus.mem_ready = 1'b1;

    // Reset state: FETCH selects but no strobes even with mem_ready high.
    #3;
    exp_v = model_out(0, 7'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset_state", 32'(ctrl_bus.state_dbg), 32'd0);
    checkOutput("reset_ctrl", 32'(dut_vec), 32'(exp_v));
    repeat (2) @(posedge clk);
    ctrl_bus.mem_ready = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    applyStimulus(7'd51, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(7'd3, 3'd2, 1'b0, 1'b0, ~32'b11000);
    applyStimulus(7'd99, 3'b000, 1'b1, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(7'd99, 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(7'd99, 3'b100, 1'b0, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(7'd99, 3'b010, 1'b1, 1'b1, 32'hFFFF_FFFF);
    applyStimulus(7'd103, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);
    applyStimulus(7'h7F, 3'd0, 1'b0, 1'b0, 32'hFFFF_FFFF);

    // Asynchronous reset in the middle of a stalled store.
    ctrl_bus.opcode    = 7'd35;
    ctrl_bus.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 ctrl_bus.mem_ready = 1'b0;
    #2;
    checkOutput("sw_state", 32'(ctrl_bus.state_dbg), 32'd5);
    checkOutput("sw_mem_write", 32'(ctrl_bus.mem_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_mem_write", 32'(ctrl_bus.mem_write), 32'd0);
    checkOutput("rst_state", 32'(ctrl_bus.state_dbg), 32'd0);
    ctrl_bus.mem_ready = 1'b1;
    #1;
    checkOutput("rst_ir_write", 32'(ctrl_bus.ir_write), 32'd0);
    rst_n = 1'b1;
    #1;
    checkOutput("rel_ir_write", 32'(ctrl_bus.ir_write), 32'd1);
    checkOutput("rel_pc_write", 32'(ctrl_bus.pc_write), 32'd1);
    ctrl_bus.mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Randomized instruction stream
    for (int i = 0; i < 300; i++) begin
      mask = $urandom | $urandom | $urandom;
      applyStimulus(op_table[$urandom_range(0, 10)], 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), mask);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
